ma_unit: RTL and testbench

MA_UNIT -- requirements
Module: ma_unit

---
 rtl/ma_unit_pkg.sv | 16 +
 rtl/ma_unit_if.sv | 29 ++
 rtl/ma_unit.sv | 162 ++++++++++++++++
 tb/tb_ma_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ma_unit_pkg.sv
// Shared constants and FSM encoding for the memory-access pipeline stage.
package ma_unit_pkg;

    localparam logic [4:0] INST_TYPE_NOP   = 5'd0;
    localparam logic [4:0] INST_TYPE_LOAD  = 5'd2;
    localparam logic [4:0] INST_TYPE_STORE = 5'd3;

    // Number of WAIT cycles allowed before an access is abandoned.
    localparam int unsigned MA_TIMEOUT = 16;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StWait = 1'b1
    } ma_state_e;

endpackage

// File: rtl/ma_unit_if.sv
// Data-memory bus between the MA stage (master) and data memory (slave).
interface ma_unit_if;

    logic        Mem_Req_Out;
    logic        Mem_We_Out;
    logic [31:0] Mem_Addr_Out;
    logic [31:0] Mem_Wdata_Out;
    logic [31:0] Mem_Rdata_In;
    logic        Mem_Ack_In;

    modport master (
        output Mem_Req_Out,
        output Mem_We_Out,
        output Mem_Addr_Out,
        output Mem_Wdata_Out,
        input  Mem_Rdata_In,
        input  Mem_Ack_In
    );

    modport slave (
        input  Mem_Req_Out,
        input  Mem_We_Out,
        input  Mem_Addr_Out,
        input  Mem_Wdata_Out,
        output Mem_Rdata_In,
        output Mem_Ack_In
    );

endinterface

// File: rtl/ma_unit.sv
// Memory-access pipeline stage: passes ALU results through, runs loads/stores on the
// data-memory bus with a bounded wait, and freezes upstream stages while an access is pending.
module ma_unit
    import ma_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Result_In,
    input  logic [31:0] Inst_In,
    input  logic [31:0] Operand_B_In,
    input  logic [4:0]  Inst_Type_In,
    ma_unit_if.master   mem,
    output logic [31:0] Result_Out,
    output logic [31:0] Inst_Out,
    output logic [31:0] Ld_Result_Out,
    output logic [4:0]  Inst_Type_Out,
    output logic        Stall_Out,
    output logic        Mem_Err_Out
);

    localparam logic [3:0] CntMax = 4'(MA_TIMEOUT - 1);

    ma_state_e   state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] inst_lat_q, inst_lat_d;
    logic [4:0]  type_lat_q, type_lat_d;
    logic [31:0] result_q, result_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] ld_q, ld_d;
    logic [4:0]  type_q, type_d;
    logic        err_q, err_d;
    logic [3:0]  cnt_q, cnt_d;

    logic is_mem;
    logic aligned;
    logic timeout;

    assign is_mem  = (Inst_Type_In == INST_TYPE_LOAD) || (Inst_Type_In == INST_TYPE_STORE);
    assign aligned = (Result_In[1:0] == 2'b00);
    assign timeout = (cnt_q == CntMax);

    // Next-state logic for the access FSM and all registered outputs.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        inst_lat_d = inst_lat_q;
        type_lat_d = type_lat_q;
        result_d   = result_q;
        inst_d     = inst_q;
        ld_d       = ld_q;
        type_d     = type_q;
        err_d      = 1'b0;
        cnt_d      = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (is_mem) begin
                    type_d = INST_TYPE_NOP;
                    if (aligned) begin
                        req_d      = 1'b1;
                        we_d       = (Inst_Type_In == INST_TYPE_STORE);
                        addr_d     = Result_In;
                        wdata_d    = Operand_B_In;
                        inst_lat_d = Inst_In;
                        type_lat_d = Inst_Type_In;
                        cnt_d      = 4'd0;
                        state_d    = StWait;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    result_d = Result_In;
                    inst_d   = Inst_In;
                    type_d   = Inst_Type_In;
                end
            end
            StWait: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (mem.Mem_Ack_In) begin
                    req_d    = 1'b0;
                    result_d = addr_q;
                    inst_d   = inst_lat_q;
                    type_d   = type_lat_q;
                    if (type_lat_q == INST_TYPE_LOAD) begin
                        ld_d = mem.Mem_Rdata_In;
                    end
                    state_d = StIdle;
                end else if (timeout) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    type_d  = INST_TYPE_NOP;
                    state_d = StIdle;
                end else begin
                    type_d = INST_TYPE_NOP;
                    cnt_d  = cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            inst_lat_q <= '0;
            type_lat_q <= INST_TYPE_NOP;
            result_q   <= '0;
            inst_q     <= '0;
            ld_q       <= '0;
            type_q     <= INST_TYPE_NOP;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            inst_lat_q <= inst_lat_d;
            type_lat_q <= type_lat_d;
            result_q   <= result_d;
            inst_q     <= inst_d;
            ld_q       <= ld_d;
            type_q     <= type_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    // Freeze upstream while an access is being issued or is still outstanding.
    always_comb begin
        Stall_Out = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StIdle:  Stall_Out = is_mem && aligned;
                StWait:  Stall_Out = !mem.Mem_Ack_In && !timeout;
                default: Stall_Out = 1'b0;
            endcase
        end
    end

    assign mem.Mem_Req_Out   = req_q;
    assign mem.Mem_We_Out    = we_q;
    assign mem.Mem_Addr_Out  = addr_q;
    assign mem.Mem_Wdata_Out = wdata_q;
    assign Result_Out        = result_q;
    assign Inst_Out          = inst_q;
    assign Ld_Result_Out     = ld_q;
    assign Inst_Type_Out     = type_q;
    assign Mem_Err_Out       = err_q;

endmodule

// File: tb/tb_ma_unit.sv
// Directed self-checking bench for the memory-access stage.
module tb_ma_unit;

    logic        clk;
    logic        rst;
    logic [31:0] result_in;
    logic [31:0] inst_in;
    logic [31:0] opb_in;
    logic [4:0]  type_in;
    logic [31:0] result_out;
    logic [31:0] inst_out;
    logic [31:0] ld_out;
    logic [4:0]  type_out;
    logic        stall;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    ma_unit_if mem_bus ();

    ma_unit dut (
        .clk          (clk),
        .rst          (rst),
        .Result_In    (result_in),
        .Inst_In      (inst_in),
        .Operand_B_In (opb_in),
        .Inst_Type_In (type_in),
        .mem          (mem_bus),
        .Result_Out   (result_out),
        .Inst_Out     (inst_out),
        .Ld_Result_Out(ld_out),
        .Inst_Type_Out(type_out),
        .Stall_Out    (stall),
        .Mem_Err_Out  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] t, input logic [31:0] r, input logic [31:0] i,
                         input logic [31:0] b);
        type_in   = t;
        result_in = r;
        inst_in   = i;
        opb_in    = b;
        #1;
    endtask

    int req_cycles;
    int stall_cycles;
    int err_early;

    initial begin
        rst = 1'b1;
        mem_bus.Mem_Ack_In   = 1'b0;
        mem_bus.Mem_Rdata_In = '0;
        drive(5'd2, 32'h100, 32'h0001_2083, 32'h0);
        tick();
        tick();
        // Reset state; stall must stay low even with an aligned load presented.
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req", 32'(mem_bus.Mem_Req_Out), 32'd0);
        check("rst_result", result_out, 32'h0);
        check("rst_type", 32'(type_out), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // ALU op passes through in one cycle without stalling.
        drive(5'd1, 32'h1234, 32'h0000_0013, 32'h0);
        rst = 1'b0;
        #1;
        check("alu_stall_pre", 32'(stall), 32'd0);
        tick();
        check("alu_result", result_out, 32'h1234);
        check("alu_inst", inst_out, 32'h0000_0013);
        check("alu_type", 32'(type_out), 32'd1);
        check("alu_stall_post", 32'(stall), 32'd0);

        // Load at 0x100, acked on the third WAIT cycle.
        drive(5'd2, 32'h100, 32'h0001_2083, 32'h0);
        check("ld_stall_idle", 32'(stall), 32'd1);
        tick();
        check("ld_w0_req", 32'(mem_bus.Mem_Req_Out), 32'd1);
        check("ld_w0_we", 32'(mem_bus.Mem_We_Out), 32'd0);
        check("ld_w0_addr", mem_bus.Mem_Addr_Out, 32'h100);
        check("ld_w0_type", 32'(type_out), 32'd0);
        check("ld_w0_stall", 32'(stall), 32'd1);
        tick();
        check("ld_w1_req", 32'(mem_bus.Mem_Req_Out), 32'd1);
        check("ld_w1_stall", 32'(stall), 32'd1);
        tick();
        mem_bus.Mem_Ack_In   = 1'b1;
        mem_bus.Mem_Rdata_In = 32'hDEAD_BEEF;
        #1;
        check("ld_w2_req", 32'(mem_bus.Mem_Req_Out), 32'd1);
        check("ld_w2_stall", 32'(stall), 32'd0);
        tick();
        mem_bus.Mem_Ack_In = 1'b0;
        drive(5'd0, 32'h0, 32'h0, 32'h0);
        check("ld_done_req", 32'(mem_bus.Mem_Req_Out), 32'd0);
        check("ld_done_data", ld_out, 32'hDEAD_BEEF);
        check("ld_done_type", 32'(type_out), 32'd2);
        check("ld_done_result", result_out, 32'h100);
        check("ld_done_inst", inst_out, 32'h0001_2083);

        // Store at 0x104, acked on the first WAIT cycle; load data must not change.
        drive(5'd3, 32'h104, 32'h00A5_2223, 32'hCAFE);
        check("st_stall_idle", 32'(stall), 32'd1);
        tick();
        mem_bus.Mem_Ack_In   = 1'b1;
        mem_bus.Mem_Rdata_In = 32'h1111_1111;
        #1;
        check("st_req", 32'(mem_bus.Mem_Req_Out), 32'd1);
        check("st_we", 32'(mem_bus.Mem_We_Out), 32'd1);
        check("st_wdata", mem_bus.Mem_Wdata_Out, 32'hCAFE);
        check("st_addr", mem_bus.Mem_Addr_Out, 32'h104);
        check("st_stall_ack", 32'(stall), 32'd0);
        tick();
        mem_bus.Mem_Ack_In = 1'b0;
        drive(5'd0, 32'h0, 32'h0, 32'h0);
        check("st_done_req", 32'(mem_bus.Mem_Req_Out), 32'd0);
        check("st_done_ld", ld_out, 32'hDEAD_BEEF);
        check("st_done_type", 32'(type_out), 32'd3);

        // Misaligned load: no request, single error pulse.
        drive(5'd2, 32'h102, 32'h0001_2083, 32'h0);
        check("mis_stall", 32'(stall), 32'd0);
        tick();
        drive(5'd0, 32'h0, 32'h0, 32'h0);
        check("mis_req", 32'(mem_bus.Mem_Req_Out), 32'd0);
        check("mis_err", 32'(err), 32'd1);
        check("mis_type", 32'(type_out), 32'd0);
        // A stray ack while idle must be ignored.
        mem_bus.Mem_Ack_In   = 1'b1;
        mem_bus.Mem_Rdata_In = 32'h2222_2222;
        tick();
        mem_bus.Mem_Ack_In = 1'b0;
        check("mis_err_clear", 32'(err), 32'd0);
        check("idle_ack_req", 32'(mem_bus.Mem_Req_Out), 32'd0);
        check("idle_ack_ld", ld_out, 32'hDEAD_BEEF);

        // Load with no ack: 16 request cycles, then timeout error.
        drive(5'd2, 32'h200, 32'h0001_2083, 32'h0);
        tick();
        req_cycles   = 0;
        stall_cycles = 0;
        err_early    = 0;
        for (int i = 0; i < 40 && mem_bus.Mem_Req_Out; i++) begin
            req_cycles++;
            if (stall) stall_cycles++;
            if (err) err_early++;
            tick();
        end
        drive(5'd0, 32'h0, 32'h0, 32'h0);
        check("to_req_cycles", 32'(req_cycles), 32'd16);
        check("to_stall_cycles", 32'(stall_cycles), 32'd15);
        check("to_err_early", 32'(err_early), 32'd0);
        check("to_err", 32'(err), 32'd1);
        check("to_type", 32'(type_out), 32'd0);
        check("to_req_after", 32'(mem_bus.Mem_Req_Out), 32'd0);
        tick();
        check("to_err_pulse", 32'(err), 32'd0);
        check("to_req_idle", 32'(mem_bus.Mem_Req_Out), 32'd0);

        // Load acked on the 16th WAIT cycle completes without error.
        drive(5'd2, 32'h300, 32'h0001_2103, 32'h0);
        tick();
        for (int i = 0; i < 15; i++) tick();
        mem_bus.Mem_Ack_In   = 1'b1;
        mem_bus.Mem_Rdata_In = 32'h5A5A_5A5A;
        #1;
        check("late_req", 32'(mem_bus.Mem_Req_Out), 32'd1);
        check("late_stall", 32'(stall), 32'd0);
        tick();
        mem_bus.Mem_Ack_In = 1'b0;
        drive(5'd0, 32'h0, 32'h0, 32'h0);
        check("late_err", 32'(err), 32'd0);
        check("late_ld", ld_out, 32'h5A5A_5A5A);
        check("late_type", 32'(type_out), 32'd2);
        check("late_req_done", 32'(mem_bus.Mem_Req_Out), 32'd0);

        // Reset during WAIT abandons the store silently.
        drive(5'd3, 32'h400, 32'h00A5_2223, 32'h77);
        tick();
        tick();
        check("rw_req", 32'(mem_bus.Mem_Req_Out), 32'd1);
        rst = 1'b1;
        #1;
        check("rw_stall", 32'(stall), 32'd0);
        tick();
        rst = 1'b0;
        drive(5'd0, 32'h0, 32'h0, 32'h0);
        check("rw_req_off", 32'(mem_bus.Mem_Req_Out), 32'd0);
        check("rw_we", 32'(mem_bus.Mem_We_Out), 32'd0);
        check("rw_addr", mem_bus.Mem_Addr_Out, 32'h0);
        check("rw_wdata", mem_bus.Mem_Wdata_Out, 32'h0);
        check("rw_result", result_out, 32'h0);
        check("rw_inst", inst_out, 32'h0);
        check("rw_ld", ld_out, 32'h0);
        check("rw_type", 32'(type_out), 32'd0);
        check("rw_err", 32'(err), 32'd0);
        tick();
        check("rw_err_after", 32'(err), 32'd0);
        check("rw_req_after", 32'(mem_bus.Mem_Req_Out), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
